ptp_gmii_tx_gen: RTL and testbench
==================================

// Module: ptp_gmii_tx_gen
// PURPOSE
//  Generates complete L2 PTPv2 event frames (Ethertype 0x88F7) on a GMII transmit interface.
//  Each frame carries a caller-supplied messageType, sequenceId and originTimestamp.
//  It is the transmit-side counterpart of the tsu GMII parser.
//  It drives tsu.gmii_ctrl/gmii_data in loopback benches and on the board TX path.
// PARAMETERS
//  DST_MAC     48'h011B19000000        destination MAC, PTP primary multicast
//  SRC_MAC     48'h000A35000102        source MAC
//  PORT_ID     80'h000A35FFFE0001020001 sourcePortIdentity (clockIdentity[63:0], portNumber[15:0])
//  IFG_CYCLES  12                      idle cycles after FCS before the next start is accepted (>=1)
// PORTS
//  gmii_txclk    in   1   125 MHz GMII TX clock; the only clock
//  rst_n         in   1   synchronous reset, active-low
//  tx_start      in   1   request one frame; sampled only when tx_busy=0
//  tx_msg_type   in   4   PTP messageType (0=Sync, 1=Delay_Req, ...); captured at start
//  tx_seq_id     in   16  sequenceId; captured at start
//  tx_origin_ts  in   80  originTimestamp {sec[47:0], ns[31:0]}; captured at start
//  tx_busy       out  1   high from the cycle after an accepted start through the last IFG cycle
//  tx_sof        out  1   1-cycle pulse coincident with the SFD byte (0xD5) on the wire
//  tx_done       out  1   1-cycle pulse coincident with the last FCS byte
//  gmii_txctrl   out  1   GMII TX_EN
//  gmii_txdata   out  8   GMII TXD
// BEHAVIOUR
//  Reset: all outputs are 0; state is IDLE; byte counter is 0; CRC register is 0xFFFFFFFF.
//  rst_n low mid-frame: TX_EN drops at the next edge, the frame is truncated, and no tx_done is issued.
//  FSM: IDLE -> PRE (7 bytes of 0x55) -> SFD (0xD5) -> DATA (60 bytes) -> FCS (4 bytes) -> IFG (IFG_CYCLES) -> IDLE.
//  Latency: start sampled high at edge N. TX_EN=1 with the first 0x55 from edge N+1. 72 wire bytes total.
//  tx_start while busy is ignored, with no queuing. Start asserted in the last IFG cycle is also ignored.
//  Back-to-back period is therefore 72+IFG_CYCLES+1 cycles.
//  All outputs are registered. TX_EN is high for exactly 72 consecutive cycles. TXD=0x00 whenever TX_EN=0.
//  DATA byte d (0..59), multi-byte fields MSB first:
//   0-5 DST_MAC | 6-11 SRC_MAC | 12-13 88 F7 | 14 {4'h0,msg_type} | 15 0x02 | 16-17 00 2C
//   18-33 0x00 (domain, reserved, flags, correctionField, reserved) | 34-43 PORT_ID | 44-45 seq_id
//   46 controlField: 0x00 if type 0, 0x01 if type 1, else 0x05 | 47 0x7F | 48-57 origin_ts | 58-59 pad 0x00
//  FCS: CRC-32 is reflected (poly 0xEDB88320), initialised to all-ones, and covers DATA bytes 0..59.
//   The transmitted FCS is ~crc, sent LSB byte first (crc[7:0] first).
//   The CRC register is updated on the same edge a DATA byte is registered out. It is reinitialised on every accepted start.
//  Counter: 7-bit byte index 0..71. The IFG counter is separate and sized by $clog2(IFG_CYCLES+1). Neither wraps mid-state.
//  tx_msg_type > 15 is impossible by width. Types 8..15 (general messages) are still sent verbatim with control 0x05.
// STRUCTURE
//  ptp_tx_pkg: state enum {IDLE,PRE,SFD,DATA,FCS,IFG}; constants ETH_PTP=16'h88F7, PTP_VER=8'h02,
//   PTP_LEN=16'd44, PREAMBLE=8'h55, SFD_BYTE=8'hD5, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3.
//  Sub-module crc32_d8: combinational next-CRC from (crc_in[31:0], data[7:0]). The register lives in the top level.
//  Top level: FSM, byte counter, captured-field registers, byte mux, output registers.
// TESTING
//  1. Reset, then start with type=0, seq=0x1234, ts={48'd5,32'd1000}.
//     Expect TX_EN rising at N+1, seven 0x55, then 0xD5 with tx_sof, and exactly 72 TX_EN cycles.
//     Expect bytes 14/44/45/46 on the wire to be 0x00/0x12/0x34/0x00, and ns bytes 00 00 03 E8.
//  2. FCS check: run the reflected CRC (init all-ones) over DA..FCS (64 bytes) of test 1.
//     The register must equal 0xDEBB20E3. The FCS must also match a bench model for type=1, seq=0xFFFF.
//  3. Feed the frame into tsu (gmii_ctrl/gmii_data).
//     Expect one q_wr_en pulse and a q_rd_data seq/type matching 0x1234/0 after q_rd_en.
//  4. Hold tx_start high continuously with IFG_CYCLES=12.
//     Expect TX_EN rising edges exactly 85 cycles apart, and TXD=0x00 during gaps.
//  5. Pulse tx_start at byte 30 of a frame.
//     Expect the frame unchanged, no second frame, and tx_done exactly once.
//  6. Drive rst_n low for 1 cycle at byte 40.
//     Expect TX_EN=0 at the next edge, tx_busy=0, and no tx_done.
//     A start 2 cycles later must produce a full, CRC-correct frame.

Source files
------------

// File: rtl/ptp_tx_pkg.sv
// ptp_tx_pkg
//   Shared types and constants for the PTPv2 layer-2 GMII frame generator.
//   - tx_state_e      : transmit FSM states
//   - Ethernet / PTP header constants, preamble and SFD bytes
//   - CRC-32 (reflected) constants
//   - Wire byte-index landmarks. One 7-bit index covers the whole 72-byte frame:
//     preamble 0..6, SFD 7, PDU 8..67, FCS 68..71.
//   - ptp_control_field(): legacy PTPv1 controlField derived from messageType
package ptp_tx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SFD  = 3'd2,
        DATA = 3'd3,
        FCS  = 3'd4,
        IFG  = 3'd5
    } tx_state_e;

    localparam logic [15:0] ETH_PTP     = 16'h88F7;
    localparam logic [7:0]  PTP_VER     = 8'h02;
    localparam logic [15:0] PTP_LEN     = 16'd44;
    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

    // Wire byte-index landmarks within one frame
    localparam logic [6:0] PRE_LAST   = 7'd6;
    localparam logic [6:0] DATA_FIRST = 7'd8;
    localparam logic [6:0] DATA_LAST  = 7'd67;
    localparam logic [6:0] FCS_LAST   = 7'd71;

    // Sync -> 0, Delay_Req -> 1, everything else (incl. general messages) -> 5
    function automatic logic [7:0] ptp_control_field(input logic [3:0] msg_type);
        logic [7:0] ctrl;
        case (msg_type)
            4'd0:    ctrl = 8'h00;
            4'd1:    ctrl = 8'h01;
            default: ctrl = 8'h05;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8
//   Combinational byte-wide step of the reflected Ethernet CRC-32
//   (polynomial 0xEDB88320, data consumed LSB first). No state.
//   Ports:
//     crc_i  [31:0]  current CRC register value
//     data_i [7:0]   byte being absorbed
//     crc_o  [31:0]  CRC register value after absorbing data_i
module crc32_d8
    import ptp_tx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    // stage[n] is the register after absorbing data bits 0..n-1
    logic [31:0] stage [0:8];

    assign stage[0] = crc_i;

    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        assign stage[gi+1] = (stage[gi][0] ^ data_i[gi])
                           ? ((stage[gi] >> 1) ^ CRC_POLY)
                           : (stage[gi] >> 1);
    end

    assign crc_o = stage[8];

endmodule

// File: rtl/ptp_gmii_tx_gen.sv
// ptp_gmii_tx_gen
//   Emits complete layer-2 PTPv2 event frames (Ethertype 0x88F7) on a GMII
//   transmit interface: 7x preamble, SFD, 60-byte PDU, 4-byte FCS, then an
//   inter-frame gap of IFG_CYCLES idle cycles before a new start is accepted.
//   Ports:
//     gmii_txclk_i          125 MHz GMII TX clock (only clock)
//     rst_n_i               synchronous reset, active low
//     tx_start_i            frame request, honoured only while idle
//     tx_msg_type_i  [3:0]  PTP messageType, captured at start
//     tx_seq_id_i    [15:0] sequenceId, captured at start
//     tx_origin_ts_i [79:0] originTimestamp {sec[47:0], ns[31:0]}, captured at start
//     tx_busy_o             high from the cycle after an accepted start to the end of the gap
//     tx_sof_o              pulse alongside the SFD byte
//     tx_done_o             pulse alongside the last FCS byte
//     gmii_txctrl_o         GMII TX_EN
//     gmii_txdata_o  [7:0]  GMII TXD (0x00 whenever TX_EN is low)
//   All outputs are registered. The FSM state at cycle k selects the byte that
//   appears on the wire after the next edge, so the first preamble byte is
//   driven one edge after the start is sampled.
module ptp_gmii_tx_gen
    import ptp_tx_pkg::*;
#(
    parameter logic [47:0] DST_MAC    = 48'h011B19000000,
    parameter logic [47:0] SRC_MAC    = 48'h000A35000102,
    parameter logic [79:0] PORT_ID    = 80'h000A35FFFE0001020001,
    parameter int unsigned IFG_CYCLES = 12
)(
    input  logic        gmii_txclk_i,
    input  logic        rst_n_i,
    input  logic        tx_start_i,
    input  logic [3:0]  tx_msg_type_i,
    input  logic [15:0] tx_seq_id_i,
    input  logic [79:0] tx_origin_ts_i,
    output logic        tx_busy_o,
    output logic        tx_sof_o,
    output logic        tx_done_o,
    output logic        gmii_txctrl_o,
    output logic [7:0]  gmii_txdata_o
);

    localparam int unsigned      IFG_W    = $clog2(IFG_CYCLES + 1);
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);

    // ------------------------------------------------------------------
    // State, counters, captured fields
    // ------------------------------------------------------------------
    tx_state_e        state_q, state_d;
    logic [6:0]       byte_cnt_q, byte_cnt_d;
    logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;

    logic [3:0]       msg_type_q;
    logic [15:0]      seq_id_q;
    logic [79:0]      origin_ts_q;
    logic [31:0]      crc_q, crc_d;

    logic             txen_q, txen_d;
    logic [7:0]       txdata_q, txdata_d;
    logic             sof_q, sof_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             start_ok;

    assign start_ok = (state_q == IDLE) && tx_start_i;

    // ------------------------------------------------------------------
    // PDU byte mux: the whole 60-byte PDU as one packed vector, byte 0 first
    // ------------------------------------------------------------------
    logic [0:59][7:0] pdu_bytes;
    logic [5:0]       pdu_idx;
    logic [7:0]       pdu_byte;
    logic [31:0]      crc_next;
    logic [31:0]      fcs;

    assign pdu_bytes = {
        DST_MAC,                          // 0-5
        SRC_MAC,                          // 6-11
        ETH_PTP,                          // 12-13
        4'h0, msg_type_q,                 // 14 transportSpecific | messageType
        PTP_VER,                          // 15
        PTP_LEN,                          // 16-17
        128'h0,                           // 18-33 domain, reserved, flags, correction, reserved
        PORT_ID,                          // 34-43
        seq_id_q,                         // 44-45
        ptp_control_field(msg_type_q),    // 46
        8'h7F,                            // 47 logMessageInterval
        origin_ts_q,                      // 48-57
        16'h0000                          // 58-59 pad to minimum frame size
    };

    assign pdu_idx  = 6'(byte_cnt_q - DATA_FIRST);
    assign pdu_byte = pdu_bytes[pdu_idx];
    assign fcs      = ~crc_q;

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (pdu_byte),
        .crc_o  (crc_next)
    );

    // ------------------------------------------------------------------
    // FSM process 1: state register and counters
    // ------------------------------------------------------------------
    always_ff @(posedge gmii_txclk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            byte_cnt_q <= 7'd0;
            ifg_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            ifg_cnt_q  <= ifg_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        ifg_cnt_d  = ifg_cnt_q;
        case (state_q)
            IDLE: begin
                if (tx_start_i) begin
                    state_d    = PRE;
                    byte_cnt_d = 7'd0;
                end
            end
            PRE: begin
                byte_cnt_d = byte_cnt_q + 7'd1;
                if (byte_cnt_q == PRE_LAST) begin
                    state_d = SFD;
                end
            end
            SFD: begin
                byte_cnt_d = byte_cnt_q + 7'd1;
                state_d    = DATA;
            end
            DATA: begin
                byte_cnt_d = byte_cnt_q + 7'd1;
                if (byte_cnt_q == DATA_LAST) begin
                    state_d = FCS;
                end
            end
            FCS: begin
                if (byte_cnt_q == FCS_LAST) begin
                    state_d    = IFG;
                    byte_cnt_d = 7'd0;
                    ifg_cnt_d  = '0;
                end else begin
                    byte_cnt_d = byte_cnt_q + 7'd1;
                end
            end
            IFG: begin
                // Start requests during the gap (including its last cycle)
                // are dropped because only IDLE looks at tx_start_i.
                if (ifg_cnt_q == IFG_LAST) begin
                    state_d   = IDLE;
                    ifg_cnt_d = '0;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + IFG_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                byte_cnt_d = 7'd0;
                ifg_cnt_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs and CRC for the next edge
    // ------------------------------------------------------------------
    always_comb begin
        txen_d   = 1'b0;
        txdata_d = 8'h00;
        sof_d    = 1'b0;
        done_d   = 1'b0;
        crc_d    = crc_q;
        busy_d   = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (tx_start_i) begin
                    crc_d = CRC_INIT;
                end
            end
            PRE: begin
                txen_d   = 1'b1;
                txdata_d = PREAMBLE;
            end
            SFD: begin
                txen_d   = 1'b1;
                txdata_d = SFD_BYTE;
                sof_d    = 1'b1;
            end
            DATA: begin
                // CRC absorbs the byte on the same edge it goes on the wire
                txen_d   = 1'b1;
                txdata_d = pdu_byte;
                crc_d    = crc_next;
            end
            FCS: begin
                // FCS indices 68..71 have low bits 00..11: LSB byte of ~crc first
                txen_d = 1'b1;
                case (byte_cnt_q[1:0])
                    2'd0:    txdata_d = fcs[7:0];
                    2'd1:    txdata_d = fcs[15:8];
                    2'd2:    txdata_d = fcs[23:16];
                    default: txdata_d = fcs[31:24];
                endcase
                done_d = (byte_cnt_q == FCS_LAST);
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Captured fields and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge gmii_txclk_i) begin
        if (!rst_n_i) begin
            msg_type_q  <= 4'd0;
            seq_id_q    <= 16'd0;
            origin_ts_q <= 80'd0;
        end else if (start_ok) begin
            msg_type_q  <= tx_msg_type_i;
            seq_id_q    <= tx_seq_id_i;
            origin_ts_q <= tx_origin_ts_i;
        end
    end

    always_ff @(posedge gmii_txclk_i) begin
        if (!rst_n_i) begin
            crc_q    <= CRC_INIT;
            txen_q   <= 1'b0;
            txdata_q <= 8'h00;
            sof_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            crc_q    <= crc_d;
            txen_q   <= txen_d;
            txdata_q <= txdata_d;
            sof_q    <= sof_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign gmii_txctrl_o = txen_q;
    assign gmii_txdata_o = txdata_q;
    assign tx_sof_o      = sof_q;
    assign tx_done_o     = done_q;
    assign tx_busy_o     = busy_q;

endmodule

// File: tb/tb_ptp_gmii_tx_gen.sv
// Testbench for ptp_gmii_tx_gen. A frame-level model predicts every output
// from the accept time of each start and the frame layout; a compare process
// checks the DUT against it each cycle, and directed tests pin literal bytes,
// the CRC residue, back-to-back spacing, start-while-busy and mid-frame reset.
module tb_ptp_gmii_tx_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_start;
    logic [3:0]  tx_msg_type;
    logic [15:0] tx_seq_id;
    logic [79:0] tx_origin_ts;
    logic        tx_busy, tx_sof, tx_done, gmii_txctrl;
    logic [7:0]  gmii_txdata;

    always #4 clk = ~clk;

    ptp_gmii_tx_gen dut (
        .gmii_txclk_i   (clk),
        .rst_n_i        (rst_n),
        .tx_start_i     (tx_start),
        .tx_msg_type_i  (tx_msg_type),
        .tx_seq_id_i    (tx_seq_id),
        .tx_origin_ts_i (tx_origin_ts),
        .tx_busy_o      (tx_busy),
        .tx_sof_o       (tx_sof),
        .tx_done_o      (tx_done),
        .gmii_txctrl_o  (gmii_txctrl),
        .gmii_txdata_o  (gmii_txdata)
    );

    int checks   = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // ---------------- frame model ----------------
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [7:0] pdu_byte(input int d, input logic [3:0] t,
                                           input logic [15:0] s, input logic [79:0] ts);
        logic [47:0] dst = 48'h011B19000000;
        logic [47:0] src = 48'h000A35000102;
        logic [79:0] pid = 80'h000A35FFFE0001020001;
        if (d < 6)        return dst[8*(5-d) +: 8];
        else if (d < 12)  return src[8*(11-d) +: 8];
        else if (d == 12) return 8'h88;
        else if (d == 13) return 8'hF7;
        else if (d == 14) return {4'h0, t};
        else if (d == 15) return 8'h02;
        else if (d == 16) return 8'h00;
        else if (d == 17) return 8'h2C;
        else if (d < 34)  return 8'h00;
        else if (d < 44)  return pid[8*(43-d) +: 8];
        else if (d == 44) return s[15:8];
        else if (d == 45) return s[7:0];
        else if (d == 46) return (t == 4'd0) ? 8'h00 : ((t == 4'd1) ? 8'h01 : 8'h05);
        else if (d == 47) return 8'h7F;
        else if (d < 58)  return ts[8*(57-d) +: 8];
        else              return 8'h00;
    endfunction

    function automatic logic [7:0] wire_byte(input int w, input logic [3:0] t,
                                            input logic [15:0] s, input logic [79:0] ts);
        logic [31:0] c;
        if (w < 7)  return 8'h55;
        if (w == 7) return 8'hD5;
        if (w < 68) return pdu_byte(w - 8, t, s, ts);
        c = 32'hFFFFFFFF;
        for (int d = 0; d < 60; d++) c = crc_upd(c, pdu_byte(d, t, s, ts));
        c = ~c;
        return c[8*(w-68) +: 8];
    endfunction

    int          edge_cnt = 0;
    logic        m_active = 1'b0;
    int          m_t0 = 0;
    logic [3:0]  m_type = 4'd0;
    logic [15:0] m_seq = 16'd0;
    logic [79:0] m_ts = 80'd0;
    logic        exp_en = 1'b0, exp_sof = 1'b0, exp_done = 1'b0, exp_busy = 1'b0;
    logic [7:0]  exp_data = 8'h00;

    // k = edges since the accepting edge; wire byte k-1 is visible after edge k.
    // Busy covers k=0..83; the next start can be accepted at k=85.
    always @(posedge clk) begin : model
        int   k;
        logic acc;
        acc = 1'b0;
        if (!rst_n) begin
            m_active <= 1'b0;
        end else if (tx_start && (!m_active || (edge_cnt - m_t0) >= 85)) begin
            acc = 1'b1;
            m_active <= 1'b1;
            m_t0     <= edge_cnt;
            m_type   <= tx_msg_type;
            m_seq    <= tx_seq_id;
            m_ts     <= tx_origin_ts;
        end
        if (!rst_n)        k = -1;
        else if (acc)      k = 0;
        else if (m_active) k = edge_cnt - m_t0;
        else               k = -1;
        exp_en   <= (k >= 1 && k <= 72);
        exp_data <= (k >= 1 && k <= 72) ? wire_byte(k - 1, m_type, m_seq, m_ts) : 8'h00;
        exp_sof  <= (k == 8);
        exp_done <= (k == 72);
        exp_busy <= (k >= 0 && k <= 83);
        edge_cnt <= edge_cnt + 1;
    end

    always @(negedge clk) begin
        if (cmp_en)
            check("cycle_model_en_data_sof_done_busy",
                  {20'h0, gmii_txctrl, gmii_txdata, tx_sof, tx_done, tx_busy},
                  {20'h0, exp_en, exp_data, exp_sof, exp_done, exp_busy});
    end

    // ---------------- wire monitor ----------------
    logic [7:0] wire_q[$];
    int         rise_q[$];
    int         sof_q[$];
    int         done_cnt = 0;
    int         gap_bad = 0;
    logic       prev_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            if (gmii_txctrl) begin
                if (tx_sof) sof_q.push_back(wire_q.size());
                wire_q.push_back(gmii_txdata);
                if (!prev_en) rise_q.push_back(edge_cnt - 1);
            end else if (gmii_txdata != 8'h00) begin
                gap_bad <= gap_bad + 1;
            end
            if (tx_done) done_cnt <= done_cnt + 1;
            prev_en <= gmii_txctrl;
        end
    end

    function automatic logic [31:0] residue(input int base);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 8; i < 72; i++) c = crc_upd(c, wire_q[base + i]);
        return c;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (tx_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (tx_busy) check({name, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic start_frame(input logic [3:0] t, input logic [15:0] s,
                               input logic [79:0] ts, output int n);
        wait_idle("start");
        @(negedge clk);
        tx_msg_type  = t;
        tx_seq_id    = s;
        tx_origin_ts = ts;
        tx_start     = 1'b1;
        n = edge_cnt;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) check({name, "_done_timeout"}, 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin : stim
        int n, base, rb, d0, sb, lim;
        logic [71:0] str;
        logic [31:0] c;

        rst_n = 1'b0; tx_start = 1'b0;
        tx_msg_type = 4'd0; tx_seq_id = 16'd0; tx_origin_ts = 80'd0;
        @(negedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_txen", {31'h0, gmii_txctrl}, 32'd0);
        check("reset_txdata", {24'h0, gmii_txdata}, 32'd0);
        check("reset_busy", {31'h0, tx_busy}, 32'd0);
        check("reset_sof_done", {30'h0, tx_sof, tx_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Model pins: standard CRC-32 check value and a few layout bytes
        str = "123456789";
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) c = crc_upd(c, str[8*(8-i) +: 8]);
        check("model_crc_check_value", ~c, 32'hCBF43926);
        check("model_ethertype_hi", {24'h0, wire_byte(20, 4'd0, 16'd0, 80'd0)}, 32'h88);
        check("model_len_lo", {24'h0, wire_byte(25, 4'd0, 16'd0, 80'd0)}, 32'h2C);

        // Test 1: Sync, seq 0x1234, ts {5 s, 1000 ns}
        base = wire_q.size(); rb = rise_q.size(); d0 = done_cnt; sb = sof_q.size();
        start_frame(4'd0, 16'h1234, {48'd5, 32'd1000}, n);
        wait_done(d0, "t1");
        check("t1_txen_latency", rise_q[rb], n + 1);
        check("t1_txen_cycles", wire_q.size() - base, 32'd72);
        for (int i = 0; i < 7; i++) check("t1_preamble", {24'h0, wire_q[base + i]}, 32'h55);
        check("t1_sfd", {24'h0, wire_q[base + 7]}, 32'hD5);
        check("t1_sof_at_sfd", sof_q[sb], base + 7);
        check("t1_msgtype_b14", {24'h0, wire_q[base + 22]}, 32'h00);
        check("t1_seq_b44", {24'h0, wire_q[base + 52]}, 32'h12);
        check("t1_seq_b45", {24'h0, wire_q[base + 53]}, 32'h34);
        check("t1_ctrl_b46", {24'h0, wire_q[base + 54]}, 32'h00);
        check("t1_ns", {wire_q[base + 62], wire_q[base + 63], wire_q[base + 64], wire_q[base + 65]},
              32'h000003E8);
        check("t1_done_once", done_cnt - d0, 32'd1);
        // Test 2: residue over PDU+FCS
        check("t2_residue", residue(base), 32'hDEBB20E3);

        // Test 2b: Delay_Req, seq 0xFFFF, FCS against model
        base = wire_q.size(); d0 = done_cnt;
        start_frame(4'd1, 16'hFFFF, {48'h0000_1234_5678, 32'h3B9A_C9FF}, n);
        wait_done(d0, "t2b");
        check("t2b_ctrl_b46", {24'h0, wire_q[base + 54]}, 32'h01);
        for (int i = 68; i < 72; i++)
            check("t2b_fcs_byte", {24'h0, wire_q[base + i]},
                  {24'h0, wire_byte(i, 4'd1, 16'hFFFF, {48'h0000_1234_5678, 32'h3B9A_C9FF})});
        check("t2b_residue", residue(base), 32'hDEBB20E3);

        // General message type: sent verbatim with control 0x05
        base = wire_q.size(); d0 = done_cnt;
        start_frame(4'd9, 16'h00A5, {48'd1, 32'd2}, n);
        wait_done(d0, "t2c");
        check("t2c_msgtype_b14", {24'h0, wire_q[base + 22]}, 32'h09);
        check("t2c_ctrl_b46", {24'h0, wire_q[base + 54]}, 32'h05);

        // Test 4: start held high -> frames every 85 cycles
        wait_idle("t4");
        rb = rise_q.size();
        @(negedge clk);
        tx_msg_type = 4'd0; tx_seq_id = 16'h0042; tx_origin_ts = {48'd7, 32'd77};
        tx_start = 1'b1;
        lim = 0;
        while (rise_q.size() < rb + 3 && lim < 400) begin
            @(negedge clk);
            lim++;
        end
        tx_start = 1'b0;
        check("t4_three_frames", rise_q.size() - rb, 32'd3);
        check("t4_period_1", rise_q[rb + 1] - rise_q[rb], 32'd85);
        check("t4_period_2", rise_q[rb + 2] - rise_q[rb + 1], 32'd85);
        wait_idle("t4_end");
        check("t4_txd_zero_in_gaps", gap_bad, 32'd0);

        // Test 5: start pulse mid-frame is ignored
        base = wire_q.size(); rb = rise_q.size(); d0 = done_cnt;
        start_frame(4'd0, 16'h5555, {48'd9, 32'd999}, n);
        lim = 0;
        while (wire_q.size() - base < 30 && lim < 200) begin
            @(negedge clk);
            lim++;
        end
        tx_msg_type = 4'd1; tx_seq_id = 16'hDEAD; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (200) @(negedge clk);
        check("t5_one_frame", rise_q.size() - rb, 32'd1);
        check("t5_done_once", done_cnt - d0, 32'd1);
        check("t5_seq_unchanged", {wire_q[base + 52], wire_q[base + 53]}, 32'h5555);
        check("t5_residue", residue(base), 32'hDEBB20E3);

        // Test 6: one-cycle reset at byte 40, then restart
        base = wire_q.size(); d0 = done_cnt;
        start_frame(4'd0, 16'h0BAD, {48'd3, 32'd4}, n);
        lim = 0;
        while (wire_q.size() - base < 40 && lim < 200) begin
            @(negedge clk);
            lim++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_txen_dropped", {31'h0, gmii_txctrl}, 32'd0);
        check("t6_busy_cleared", {31'h0, tx_busy}, 32'd0);
        check("t6_no_done_truncated", done_cnt - d0, 32'd0);
        @(negedge clk);
        base = wire_q.size();
        start_frame(4'd0, 16'h1001, {48'd11, 32'd12}, n);
        wait_done(d0, "t6");
        check("t6_restart_len", wire_q.size() - base, 32'd72);
        check("t6_done_once", done_cnt - d0, 32'd1);
        check("t6_residue", residue(base), 32'hDEBB20E3);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
